// File: rtl/dram_sched.sv
// DRAM access/refresh scheduler: CPU RAS/CAS sequencing plus CAS-before-RAS refresh.
// Optional DRAM_SCHED_LATE_WRITE_EN adds one extra column cycle to writes.
module dram_sched #(
  parameter int REF_INTERVAL = 13,
  parameter int PEND_MAX     = 4
) (
  input  logic       C7M,
  input  logic       RES,
  input  logic       CPUReq,
  input  logic       CPUWE,
  input  logic       CPUBank,
  input  logic       RefTick,
  output logic       CPUAck,
  output logic       Busy,
  output logic       nRAS,
  output logic       nCAS0,
  output logic       nCAS1,
  output logic       CASel,
  output logic [2:0] RefPend,
  output logic       RefOvf
);

  typedef enum logic [3:0] {
    IDLE, ROW, COL, COLW, CAS1, CAS2, PRE,
    RCAS, RRAS, RHOLD, RPRE
  } state_t;

  localparam logic [7:0] LAST = 8'(REF_INTERVAL - 1);
  localparam logic [2:0] PMAX = 3'(PEND_MAX);

  state_t     state, nxt;
  logic       we_q, bank_q;
  logic [7:0] cnt;
  logic       ref_req, ref_done;

  assign ref_req  = RefTick && (cnt == LAST);
  assign ref_done = (state == RPRE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (RefPend >= PMAX)     nxt = RCAS;
        else if (CPUReq)         nxt = ROW;
        else if (RefPend != 3'd0) nxt = RCAS;
        else                     nxt = IDLE;
      end
      ROW:  nxt = COL;
`ifdef DRAM_SCHED_LATE_WRITE_EN
      COL:  nxt = we_q ? COLW : CAS1;
`else
      COL:  nxt = CAS1;
`endif
      COLW:  nxt = CAS1;
      CAS1:  nxt = CAS2;
      CAS2:  nxt = PRE;
      PRE:   nxt = IDLE;
      RCAS:  nxt = RRAS;
      RRAS:  nxt = RHOLD;
      RHOLD: nxt = RPRE;
      RPRE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      bank_q  <= 1'b0;
      cnt     <= 8'd0;
      RefPend <= 3'd0;
      RefOvf  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == ROW) begin
        we_q   <= CPUWE;
        bank_q <= CPUBank;
      end
      if (RefTick)
        cnt <= ref_req ? 8'd0 : cnt + 8'd1;
      if (ref_req && RefPend == 3'd7)
        RefOvf <= 1'b1;
      // simultaneous request and completion cancel out
      if (ref_req && !ref_done && RefPend != 3'd7)
        RefPend <= RefPend + 3'd1;
      else if (!ref_req && ref_done)
        RefPend <= RefPend - 3'd1;
    end
  end

  always_comb begin
    nRAS   = 1'b1;
    nCAS0  = 1'b1;
    nCAS1  = 1'b1;
    CASel  = 1'b0;
    CPUAck = 1'b0;
    Busy   = (state != IDLE);
    unique case (state)
      ROW: nRAS = 1'b0;
      COL, COLW: begin
        nRAS  = 1'b0;
        CASel = 1'b1;
      end
      CAS1, CAS2: begin
        nRAS  = 1'b0;
        CASel = 1'b1;
        nCAS0 = bank_q;
        nCAS1 = !bank_q;
      end
      PRE: CPUAck = 1'b1;
      RCAS: begin
        nCAS0 = 1'b0;
        nCAS1 = 1'b0;
      end
      RRAS: begin
        nRAS  = 1'b0;
        nCAS0 = 1'b0;
        nCAS1 = 1'b0;
      end
      RHOLD: nRAS = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_sched.sv
// Directed bench for dram_sched: expected strobe traces queued, then
// popped and compared cycle by cycle; a second instance uses REF_INTERVAL=2.
module tb_dram_sched;

  logic C7M = 1'b0;
  logic RES, CPUReq, CPUWE, CPUBank, RefTick;
  logic CPUAck, Busy, nRAS, nCAS0, nCAS1, CASel, RefOvf;
  logic [2:0] RefPend;
  logic f_ack, f_busy, f_nras, f_ncas0, f_ncas1, f_casel, f_ovf;
  logic [2:0] f_pend;

  int nvec = 0;
  int nerr = 0;
  logic [5:0] exp_q[$];

  localparam logic [5:0] V_IDLE  = 6'b011100;
  localparam logic [5:0] V_ROW   = 6'b101100;
  localparam logic [5:0] V_COL   = 6'b101110;
  localparam logic [5:0] V_CASB1 = 6'b101010;
  localparam logic [5:0] V_CASB0 = 6'b100110;
  localparam logic [5:0] V_PRE   = 6'b111101;
  localparam logic [5:0] V_RCAS  = 6'b110000;
  localparam logic [5:0] V_RRAS  = 6'b100000;
  localparam logic [5:0] V_RHOLD = 6'b101100;
  localparam logic [5:0] V_RPRE  = 6'b111100;

  dram_sched dut (
    .C7M(C7M), .RES(RES), .CPUReq(CPUReq), .CPUWE(CPUWE),
    .CPUBank(CPUBank), .RefTick(RefTick), .CPUAck(CPUAck),
    .Busy(Busy), .nRAS(nRAS), .nCAS0(nCAS0), .nCAS1(nCAS1),
    .CASel(CASel), .RefPend(RefPend), .RefOvf(RefOvf)
  );

  dram_sched #(.REF_INTERVAL(2), .PEND_MAX(4)) fast (
    .C7M(C7M), .RES(RES), .CPUReq(CPUReq), .CPUWE(CPUWE),
    .CPUBank(CPUBank), .RefTick(RefTick), .CPUAck(f_ack),
    .Busy(f_busy), .nRAS(f_nras), .nCAS0(f_ncas0), .nCAS1(f_ncas1),
    .CASel(f_casel), .RefPend(f_pend), .RefOvf(f_ovf)
  );

  always #5 C7M = ~C7M;

  function automatic logic [5:0] vec();
    return {Busy, nRAS, nCAS0, nCAS1, CASel, CPUAck};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge C7M);
    #1;
  endtask

  task automatic push_cpu(input bit we, input bit bank);
    exp_q.push_back(V_ROW);
    exp_q.push_back(V_COL);
`ifdef DRAM_SCHED_LATE_WRITE_EN
    if (we) exp_q.push_back(V_COL);
`endif
    exp_q.push_back(bank ? V_CASB1 : V_CASB0);
    exp_q.push_back(bank ? V_CASB1 : V_CASB0);
    exp_q.push_back(V_PRE);
    exp_q.push_back(V_IDLE);
  endtask

  task automatic push_ref();
    exp_q.push_back(V_RCAS);
    exp_q.push_back(V_RRAS);
    exp_q.push_back(V_RHOLD);
    exp_q.push_back(V_RPRE);
    exp_q.push_back(V_IDLE);
  endtask

  task automatic drain(input string tag, input bit hold);
    logic [5:0] e;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      chk(tag, {2'b0, vec()}, {2'b0, e});
      if (CPUAck && !hold) CPUReq = 1'b0;
    end
  endtask

  // request, then scramble WE/bank right after acceptance
  task automatic cpu(input bit we, input bit bank, input string tag);
    logic [5:0] e;
    CPUWE = we;
    CPUBank = bank;
    CPUReq = 1'b1;
    push_cpu(we, bank);
    step();
    e = exp_q.pop_front();
    chk(tag, {2'b0, vec()}, {2'b0, e});
    CPUWE = !we;
    CPUBank = !bank;
    drain(tag, 1'b0);
  endtask

  initial begin
    int n;
    RES = 1'b1;
    CPUReq = 1'b0;
    CPUWE = 1'b0;
    CPUBank = 1'b0;
    RefTick = 1'b0;
    #1;
    chk("rst_vec", {2'b0, vec()}, {2'b0, V_IDLE});
    step();
    step();
    chk("rst_pend", {5'b0, RefPend}, 8'd0);
    chk("rst_ovf", {7'b0, RefOvf}, 8'd0);
    RES = 1'b0;
    step();
    chk("idle", {2'b0, vec()}, {2'b0, V_IDLE});

    cpu(1'b0, 1'b1, "rd_b1");
    cpu(1'b1, 1'b0, "wr_b0");
    cpu(1'b0, 1'b0, "rd_b0");
    cpu(1'b1, 1'b1, "wr_b1");

    // request held through PRE: IDLE first, then a fresh access
    CPUWE = 1'b0;
    CPUBank = 1'b1;
    CPUReq = 1'b1;
    push_cpu(1'b0, 1'b1);
    exp_q.push_back(V_ROW);
    drain("hold", 1'b1);
    CPUReq = 1'b0;
    exp_q.push_back(V_COL);
    exp_q.push_back(V_CASB1);
    exp_q.push_back(V_CASB1);
    exp_q.push_back(V_PRE);
    exp_q.push_back(V_IDLE);
    drain("hold_tail", 1'b0);

    // request withdrawn before any edge sees it
    CPUReq = 1'b1;
    #3;
    CPUReq = 1'b0;
    step();
    chk("drop", {2'b0, vec()}, {2'b0, V_IDLE});

    // 13 ticks -> one CBR refresh
    for (int i = 0; i < 13; i++) begin
      RefTick = 1'b1;
      step();
      RefTick = 1'b0;
      if (i == 11) chk("pend_12", {5'b0, RefPend}, 8'd0);
    end
    chk("pend_13", {5'b0, RefPend}, 8'd1);
    chk("idle_13", {2'b0, vec()}, {2'b0, V_IDLE});
    push_ref();
    drain("cbr", 1'b0);
    chk("pend_done", {5'b0, RefPend}, 8'd0);

    // refresh overrides CPU once four are pending
    CPUWE = 1'b0;
    CPUBank = 1'b0;
    CPUReq = 1'b1;
    RefTick = 1'b1;
    n = 0;
    while (RefPend != 3'd4 && n < 200) begin
      step();
      n++;
    end
    RefTick = 1'b0;
    chk("pend4", {5'b0, RefPend}, 8'd4);
    n = 0;
    while (Busy && n < 20) begin
      step();
      n++;
    end
    chk("pend4_idle", {7'b0, Busy}, 8'd0);
    push_ref();
    push_cpu(1'b0, 1'b0);
    drain("ovr", 1'b0);
    chk("pend3", {5'b0, RefPend}, 8'd3);
    n = 0;
    while ((RefPend != 3'd0 || Busy) && n < 100) begin
      step();
      n++;
    end
    chk("drained", {5'b0, RefPend}, 8'd0);

    // saturation on the REF_INTERVAL=2 instance
    RES = 1'b1;
    step();
    RES = 1'b0;
    CPUReq = 1'b1;
    RefTick = 1'b1;
    n = 0;
    while (!f_ovf && n < 300) begin
      step();
      n++;
    end
    chk("sat_ovf", {7'b0, f_ovf}, 8'd1);
    chk("sat_pend", {5'b0, f_pend}, 8'd7);
    CPUReq = 1'b0;
    RefTick = 1'b0;
    n = 0;
    while ((f_pend != 3'd0 || f_busy) && n < 100) begin
      step();
      n++;
    end
    chk("sat_drain", {5'b0, f_pend}, 8'd0);
    chk("ovf_sticky", {7'b0, f_ovf}, 8'd1);

    // async reset inside CAS1 of a write
    RES = 1'b1;
    step();
    RES = 1'b0;
    step();
    CPUWE = 1'b1;
    CPUBank = 1'b1;
    CPUReq = 1'b1;
    step();
    step();
`ifdef DRAM_SCHED_LATE_WRITE_EN
    step();
`endif
    step();
    chk("wr_cas1", {2'b0, vec()}, {2'b0, V_CASB1});
    #2;
    RES = 1'b1;
    CPUReq = 1'b0;
    #1;
    chk("async_rst", {2'b0, vec()}, {2'b0, V_IDLE});
    chk("rst_pend2", {5'b0, RefPend}, 8'd0);
    step();
    RES = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_ack", {2'b0, vec()}, {2'b0, V_IDLE});
    end
    chk("ovf_cleared", {7'b0, f_ovf}, 8'd0);

    cpu(1'b1, 1'b0, "wr_post");
    cpu(1'b0, 1'b1, "rd_post");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
